// File: rtl/exec_operand_stage_pkg.sv
// Shared pipeline types for the operand stage: operand/op classes, buffer entry and buffer state.
// Entry fields are DataWidth bits wide; the stage's XLEN parameter is expected to match.
package PipelineTypes;

   localparam int unsigned DataWidth = 32;

   typedef enum logic [1:0] {
      OP_TYPE_REG,
      OP_TYPE_IMM,
      OP_TYPE_PC,
      OP_TYPE_ZERO
   } OperandType;

   typedef enum logic [2:0] {
      TYPE_R,
      TYPE_I,
      TYPE_S,
      TYPE_B,
      TYPE_U,
      TYPE_J,
      TYPE_JALR
   } OpType;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } BufferState;

   typedef struct packed {
      logic [DataWidth-1:0] aluOp1;
      logic [DataWidth-1:0] aluOp2;
      logic [DataWidth-1:0] npcOp1;
      logic [DataWidth-1:0] npcOp2;
   } OperandStageEntry;

endpackage

// File: rtl/exec_operand_stage_operand_bypass_mux.sv
// Priority forwarding mux for one source register; channel 0 wins. Forwarding is only
// built when OPERAND_BYPASS_EN is defined, otherwise the register-file value passes through.
module operand_bypass_mux #(
   parameter int unsigned NUM_BYPASS = 2,
   parameter int unsigned XLEN       = 32
) (
   input  logic [4:0]                       rsAddr,
   input  logic [XLEN-1:0]                  rsData,
   input  logic [NUM_BYPASS-1:0]            bypassValid,
   input  logic [NUM_BYPASS-1:0][4:0]       bypassAddr,
   input  logic [NUM_BYPASS-1:0][XLEN-1:0]  bypassData,
   output logic [XLEN-1:0]                  effData
);

`ifdef OPERAND_BYPASS_EN
   // Walk from the oldest channel to the youngest so the lowest index overrides.
   always_comb begin
      effData = rsData;
      for (int i = int'(NUM_BYPASS) - 1; i >= 0; i--) begin
         if (rsAddr != 5'd0 && bypassValid[i] && bypassAddr[i] == rsAddr) begin
            effData = bypassData[i];
         end
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{rsAddr, bypassValid, bypassAddr, bypassData};
   assign effData       = rsData;
`endif

endmodule

// File: rtl/exec_operand_stage.sv
// Registered operand-preparation stage with forwarding and a two-entry skid buffer.
// Forwarding is enabled by defining OPERAND_BYPASS_EN.
module exec_operand_stage
   import PipelineTypes::*;
#(
   parameter int unsigned XLEN       = DataWidth,
   parameter int unsigned NUM_BYPASS = 2
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic                             flush,
   input  logic                             inValid,
   output logic                             inReady,
   input  logic [XLEN-1:0]                  pc,
   input  logic [XLEN-1:0]                  imm,
   input  logic [XLEN-1:0]                  rs1Data,
   input  logic [XLEN-1:0]                  rs2Data,
   input  logic [4:0]                       rs1Addr,
   input  logic [4:0]                       rs2Addr,
   input  OperandType                       aluOp1Type,
   input  OperandType                       aluOp2Type,
   input  OpType                            opType,
   input  logic [NUM_BYPASS-1:0]            bypassValid,
   input  logic [NUM_BYPASS-1:0][4:0]       bypassAddr,
   input  logic [NUM_BYPASS-1:0][XLEN-1:0]  bypassData,
   output logic                             outValid,
   input  logic                             outReady,
   output logic [XLEN-1:0]                  aluOp1,
   output logic [XLEN-1:0]                  aluOp2,
   output logic [XLEN-1:0]                  npcOp1,
   output logic [XLEN-1:0]                  npcOp2
);

   logic [XLEN-1:0]  rs1_eff, rs2_eff;
   OperandStageEntry new_entry;
   OperandStageEntry head_q, head_d, tail_q, tail_d;
   BufferState       state_q, state_d;
   logic             in_ready_q;
   logic             accept, drain;

   operand_bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN)) u_rs1_mux (
      .rsAddr      (rs1Addr),
      .rsData      (rs1Data),
      .bypassValid (bypassValid),
      .bypassAddr  (bypassAddr),
      .bypassData  (bypassData),
      .effData     (rs1_eff)
   );

   operand_bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN)) u_rs2_mux (
      .rsAddr      (rs2Addr),
      .rsData      (rs2Data),
      .bypassValid (bypassValid),
      .bypassAddr  (bypassAddr),
      .bypassData  (bypassData),
      .effData     (rs2_eff)
   );

   function automatic logic [XLEN-1:0] sel_operand(input OperandType t, input logic [XLEN-1:0] rs,
                                                   input logic [XLEN-1:0] pcv,
                                                   input logic [XLEN-1:0] immv);
      unique case (t)
         OP_TYPE_REG: sel_operand = rs;
         OP_TYPE_IMM: sel_operand = immv;
         OP_TYPE_PC:  sel_operand = pcv;
         default:     sel_operand = '0;
      endcase
   endfunction

   always_comb begin
      new_entry        = '0;
      new_entry.aluOp1 = sel_operand(aluOp1Type, rs1_eff, pc, imm);
      new_entry.aluOp2 = sel_operand(aluOp2Type, rs2_eff, pc, imm);
      case (opType)
         TYPE_B, TYPE_J: begin
            new_entry.npcOp1 = pc;
            new_entry.npcOp2 = imm;
         end
         TYPE_JALR: begin
            new_entry.npcOp1 = rs1_eff;
            new_entry.npcOp2 = imm;
         end
         default: begin
            new_entry.npcOp1 = pc;
            new_entry.npcOp2 = XLEN'(32'd4);
         end
      endcase
   end

   assign accept = inValid & in_ready_q & ~flush;
   assign drain  = outValid & outReady;

   // head_q is always the oldest entry; tail_q only holds data in StFull.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  head_d  = new_entry;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && drain) begin
                  head_d = new_entry;
               end else if (accept) begin
                  tail_d  = new_entry;
                  state_d = StFull;
               end else if (drain) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (drain) begin
                  head_d  = tail_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= StEmpty;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= (state_d != StFull);
      end
   end

   assign inReady  = in_ready_q;
   assign outValid = (state_q != StEmpty);
   assign aluOp1   = head_q.aluOp1;
   assign aluOp2   = head_q.aluOp2;
   assign npcOp1   = head_q.npcOp1;
   assign npcOp2   = head_q.npcOp2;

endmodule

// File: tb/tb_exec_operand_stage.sv
// Self-checking bench for exec_operand_stage: directed cases plus a randomized scoreboard run.
module tb_exec_operand_stage;
   import PipelineTypes::*;

   localparam int XLEN = 32;
   localparam int NB   = 2;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic flush = 1'b0;
   logic inValid = 1'b0;
   logic outReady = 1'b0;
   logic inReady, outValid;
   logic [XLEN-1:0] pc, imm, rs1Data, rs2Data;
   logic [4:0] rs1Addr, rs2Addr;
   OperandType aluOp1Type, aluOp2Type;
   OpType opType;
   logic [NB-1:0] bypassValid;
   logic [NB-1:0][4:0] bypassAddr;
   logic [NB-1:0][XLEN-1:0] bypassData;
   logic [XLEN-1:0] aluOp1, aluOp2, npcOp1, npcOp2;

   OperandStageEntry sb[$];
   int n_checks = 0;
   int n_fail = 0;
   logic [XLEN-1:0] exp_fwd;

   always #5 clk = ~clk;

   exec_operand_stage #(.XLEN(XLEN), .NUM_BYPASS(NB)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .flush       (flush),
      .inValid     (inValid),
      .inReady     (inReady),
      .pc          (pc),
      .imm         (imm),
      .rs1Data     (rs1Data),
      .rs2Data     (rs2Data),
      .rs1Addr     (rs1Addr),
      .rs2Addr     (rs2Addr),
      .aluOp1Type  (aluOp1Type),
      .aluOp2Type  (aluOp2Type),
      .opType      (opType),
      .bypassValid (bypassValid),
      .bypassAddr  (bypassAddr),
      .bypassData  (bypassData),
      .outValid    (outValid),
      .outReady    (outReady),
      .aluOp1      (aluOp1),
      .aluOp2      (aluOp2),
      .npcOp1      (npcOp1),
      .npcOp2      (npcOp2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] ref_fwd(input logic [4:0] a, input logic [XLEN-1:0] d);
      ref_fwd = d;
`ifdef OPERAND_BYPASS_EN
      if (a != 5'd0) begin
         if (bypassValid[1] && bypassAddr[1] == a) ref_fwd = bypassData[1];
         if (bypassValid[0] && bypassAddr[0] == a) ref_fwd = bypassData[0];
      end
`endif
   endfunction

   function automatic logic [XLEN-1:0] ref_sel(input OperandType t, input logic [XLEN-1:0] rs);
      if (t == OP_TYPE_REG) return rs;
      if (t == OP_TYPE_IMM) return imm;
      if (t == OP_TYPE_PC) return pc;
      return '0;
   endfunction

   function automatic OperandStageEntry ref_entry();
      OperandStageEntry e;
      logic [XLEN-1:0] r1, r2;
      r1 = ref_fwd(rs1Addr, rs1Data);
      r2 = ref_fwd(rs2Addr, rs2Data);
      e.aluOp1 = ref_sel(aluOp1Type, r1);
      e.aluOp2 = ref_sel(aluOp2Type, r2);
      if (opType == TYPE_B || opType == TYPE_J) begin
         e.npcOp1 = pc;  e.npcOp2 = imm;
      end else if (opType == TYPE_JALR) begin
         e.npcOp1 = r1;  e.npcOp2 = imm;
      end else begin
         e.npcOp1 = pc;  e.npcOp2 = 32'd4;
      end
      return e;
   endfunction

   // Scoreboard: handshakes are decided by the values seen here, half a cycle before the edge.
   always @(negedge clk) begin
      if (rstN) begin
         if (flush) begin
            sb.delete();
         end else begin
            if (outValid && outReady) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 32'(outValid), 32'd0);
               end else begin
                  OperandStageEntry e;
                  e = sb.pop_front();
                  check("sb_aluOp1", aluOp1, e.aluOp1);
                  check("sb_aluOp2", aluOp2, e.aluOp2);
                  check("sb_npcOp1", npcOp1, e.npcOp1);
                  check("sb_npcOp2", npcOp2, e.npcOp2);
               end
            end
            if (inValid && inReady) sb.push_back(ref_entry());
         end
      end
   end

   task automatic xfer();
      int cnt = 0;
      @(posedge clk); #1 inValid = 1'b1;
      @(negedge clk);
      while (!inReady && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      if (!inReady) check("in_timeout", 32'(inReady), 32'd1);
      @(posedge clk); #1 inValid = 1'b0;
   endtask

   task automatic rand_inputs();
      pc = $urandom; imm = $urandom; rs1Data = $urandom; rs2Data = $urandom;
      rs1Addr = 5'($urandom_range(0, 3));
      rs2Addr = 5'($urandom_range(0, 3));
      aluOp1Type = OperandType'($urandom_range(0, 3));
      aluOp2Type = OperandType'($urandom_range(0, 3));
      opType = OpType'($urandom_range(0, 6));
      bypassValid = NB'($urandom_range(0, 3));
      for (int i = 0; i < NB; i++) begin
         bypassAddr[i] = 5'($urandom_range(0, 3));
         bypassData[i] = $urandom;
      end
   endtask

   task automatic set_reg_op(input logic [XLEN-1:0] v);
      aluOp1Type = OP_TYPE_REG; rs1Addr = 5'd7; rs1Data = v; bypassValid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pc = '0; imm = '0; rs1Data = '0; rs2Data = '0; rs1Addr = '0; rs2Addr = '0;
      aluOp1Type = OP_TYPE_REG; aluOp2Type = OP_TYPE_REG; opType = TYPE_R;
      bypassValid = '0; bypassAddr = '0; bypassData = '0;

      repeat (2) @(negedge clk);
      check("rst_outValid", 32'(outValid), 32'd0);
      check("rst_inReady", 32'(inReady), 32'd1);
      check("rst_aluOp1", aluOp1, 32'd0);
      check("rst_npcOp2", npcOp2, 32'd0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      check("rel_outValid", 32'(outValid), 32'd0);
      check("rel_inReady", 32'(inReady), 32'd1);
      check("rel_aluOp2", aluOp2, 32'd0);

      // Forwarding priority, then address 0 never forwarded
      outReady = 1'b1;
      aluOp1Type = OP_TYPE_REG; rs1Addr = 5'd5; rs1Data = 32'h10;
      bypassValid = 2'b11; bypassAddr[0] = 5'd5; bypassAddr[1] = 5'd5;
      bypassData[0] = 32'h22; bypassData[1] = 32'h33;
`ifdef OPERAND_BYPASS_EN
      exp_fwd = 32'h22;
`else
      exp_fwd = 32'h10;
`endif
      xfer();
      @(negedge clk);
      check("latency_outValid", 32'(outValid), 32'd1);
      check("fwd_prio", aluOp1, exp_fwd);
      rs1Addr = 5'd0; bypassAddr[0] = 5'd0; bypassAddr[1] = 5'd0;
      xfer();
      @(negedge clk);
      check("fwd_x0", aluOp1, 32'h10);

      // Next-PC operands
      bypassValid = '0; opType = TYPE_JALR; rs1Addr = 5'd3; rs1Data = 32'h1000; imm = 32'h8;
      xfer();
      @(negedge clk);
      check("jalr_npc1", npcOp1, 32'h1000);
      check("jalr_npc2", npcOp2, 32'h8);
      opType = TYPE_R; pc = 32'h200;
      xfer();
      @(negedge clk);
      check("seq_npc1", npcOp1, 32'h200);
      check("seq_npc2", npcOp2, 32'd4);

      // Backpressure: A and B absorbed, C stalls, then FIFO order
      @(posedge clk); #1 outReady = 1'b0; set_reg_op(32'hA); inValid = 1'b1;
      @(posedge clk); #1 set_reg_op(32'hB);
      @(posedge clk); #1 set_reg_op(32'hC);
      @(negedge clk);
      check("full_inReady", 32'(inReady), 32'd0);
      check("full_head", aluOp1, 32'hA);
      repeat (2) @(negedge clk);
      check("stall_hold", aluOp1, 32'hA);
      check("stall_inReady", 32'(inReady), 32'd0);
      @(posedge clk); #1 outReady = 1'b1;
      @(negedge clk);
      check("order_A", aluOp1, 32'hA);
      @(negedge clk);
      check("order_B", aluOp1, 32'hB);
      check("refill_inReady", 32'(inReady), 32'd1);
      @(posedge clk); #1 inValid = 1'b0;
      @(negedge clk);
      check("order_C", aluOp1, 32'hC);
      check("order_C_valid", 32'(outValid), 32'd1);
      @(negedge clk);
      check("empty_after_C", 32'(outValid), 32'd0);

      // Flush from FULL with an input offered
      @(posedge clk); #1 outReady = 1'b0; set_reg_op(32'hD); inValid = 1'b1;
      @(posedge clk); #1 set_reg_op(32'hE);
      @(posedge clk); #1 set_reg_op(32'hF); flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; inValid = 1'b0;
      @(negedge clk);
      check("flush_full_outValid", 32'(outValid), 32'd0);
      check("flush_full_inReady", 32'(inReady), 32'd1);
      outReady = 1'b1;
      repeat (3) @(negedge clk);
      check("flush_full_drop", 32'(outValid), 32'd0);

      // Flush from ONE while inReady is high: offered input still dropped
      @(posedge clk); #1 outReady = 1'b0; set_reg_op(32'h11); inValid = 1'b1;
      @(posedge clk); #1 set_reg_op(32'h12); flush = 1'b1;
      @(negedge clk);
      check("flush_one_inReady", 32'(inReady), 32'd1);
      @(posedge clk); #1 flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      repeat (3) @(negedge clk);
      check("flush_one_drop", 32'(outValid), 32'd0);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         rand_inputs();
         inValid = 1'($urandom_range(0, 1));
         outReady = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 24) == 0);
      end
      @(posedge clk); #1 inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("drained_outValid", 32'(outValid), 32'd0);

      // Asynchronous reset with an entry buffered
      outReady = 1'b0; set_reg_op(32'h55); aluOp2Type = OP_TYPE_IMM; imm = 32'h66;
      xfer();
      @(posedge clk); #3 rstN = 1'b0;
      #1;
      check("arst_outValid", 32'(outValid), 32'd0);
      check("arst_aluOp1", aluOp1, 32'd0);
      check("arst_aluOp2", aluOp2, 32'd0);
      check("arst_inReady", 32'(inReady), 32'd1);
      sb.delete();
      @(negedge clk); rstN = 1'b1;
      repeat (2) @(negedge clk);
      check("post_arst_outValid", 32'(outValid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
